// File: rtl/mem_wb_writeback.sv
// Write-back stage: a skid queue sits in front of the register-file write port and bypasses pending results to the ID operands.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] MemData_in,
    input  logic [ADDR_W-1:0] RdAddr_in,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    input  logic [DATA_W-1:0] RsData_rf,
    input  logic [DATA_W-1:0] RtData_rf,
    output logic [DATA_W-1:0] RsData_fwd,
    output logic [DATA_W-1:0] RtData_fwd,
    output logic [31:0]       retire_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

    wb_entry_t     q [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          accept, push, pop;

    assign in_ready = (count != CW'(DEPTH));
    assign accept   = in_valid & in_ready;
    // Non-writers and $0 targets complete the handshake but never occupy a slot.
    assign push     = accept & RegWrite_in & (RdAddr_in != '0);
    assign pop      = rf_we & rf_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            q[tail].waddr <= RdAddr_in;
            q[tail].wdata <= MemtoReg_in ? MemData_in : ALU_result_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (count != '0) begin
            rf_we    = 1'b1;
            rf_waddr = q[head].waddr;
            rf_wdata = q[head].wdata;
        end
    end

    // Walk oldest to youngest so the last match (the newest value) wins.
    always_comb begin
        RsData_fwd = RsData_rf;
        RtData_fwd = RtData_rf;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (RsAddr != '0 && q[head + PW'(i)].waddr == RsAddr)
                    RsData_fwd = q[head + PW'(i)].wdata;
                if (RtAddr != '0 && q[head + PW'(i)].waddr == RtAddr)
                    RtData_fwd = q[head + PW'(i)].wdata;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)         cnt <= '0;
        else if (accept) cnt <= cnt + 32'd1;
    end

    assign retire_cnt = cnt;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed vector table, hand-written reset sequence, and a randomized stream against a queue model.
module tb_mem_wb_writeback;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, RegWrite_in, MemtoReg_in;
    logic [DW-1:0] ALU_result_in, MemData_in;
    logic [AW-1:0] RdAddr_in;
    logic          rf_we, rf_ready;
    logic [AW-1:0] rf_waddr, RsAddr, RtAddr;
    logic [DW-1:0] rf_wdata, RsData_rf, RtData_rf, RsData_fwd, RtData_fwd;
    logic [31:0]   retire_cnt;

    mem_wb_writeback #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .ALU_result_in(ALU_result_in), .MemData_in(MemData_in), .RdAddr_in(RdAddr_in),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
        .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData_rf(RsData_rf), .RtData_rf(RtData_rf),
        .RsData_fwd(RsData_fwd), .RtData_fwd(RtData_fwd), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes as a plain FIFO, index 0 = oldest.
    logic [AW-1:0] mq_a[$];
    logic [DW-1:0] mq_d[$];
    int unsigned   mret = 0;
    int            model_writes = 0;
    int            dut_writes = 0;

    typedef struct {
        logic          iv, rw, m2r;
        logic [AW-1:0] rd;
        logic [DW-1:0] alu, mem;
        logic          rdy;
        logic [AW-1:0] rs, rt;
        logic          e_rdy, e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd, e_rs, e_rt;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ret_exp(input int unsigned n);
`ifdef WB_RETIRE_CNT_EN
        return n;
`else
        return 32'd0 & n;
`endif
    endfunction

    task automatic check_model(input string tag);
        logic [DW-1:0] ers, ert;
        int            sz;
        sz  = mq_a.size();
        ers = RsData_rf;
        ert = RtData_rf;
        for (int i = 0; i < sz; i++) begin
            if (RsAddr != '0 && mq_a[i] == RsAddr) ers = mq_d[i];
            if (RtAddr != '0 && mq_a[i] == RtAddr) ert = mq_d[i];
        end
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, sz < D});
        chk({tag, ".rf_we"},    {31'd0, rf_we},    {31'd0, sz != 0});
        chk({tag, ".rf_waddr"}, {27'd0, rf_waddr}, (sz != 0) ? {27'd0, mq_a[0]} : 32'd0);
        chk({tag, ".rf_wdata"}, rf_wdata, (sz != 0) ? mq_d[0] : 32'd0);
        chk({tag, ".rs_fwd"},   RsData_fwd, ers);
        chk({tag, ".rt_fwd"},   RtData_fwd, ert);
    endtask

    // Advance the model by one clock edge using the inputs that were held across it.
    task automatic model_edge();
        int sz;
        sz = mq_a.size();
        if (rst) begin
            mq_a.delete();
            mq_d.delete();
            mret = 0;
            return;
        end
        if (in_valid && sz < D) mret++;
        if (sz != 0 && rf_ready) begin
            void'(mq_a.pop_front());
            void'(mq_d.pop_front());
            model_writes++;
        end
        if (in_valid && sz < D && RegWrite_in && RdAddr_in != '0) begin
            mq_a.push_back(RdAddr_in);
            mq_d.push_back(MemtoReg_in ? MemData_in : ALU_result_in);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic rw, input logic m2r, input logic [AW-1:0] rd,
                         input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic rdy);
        in_valid = iv; RegWrite_in = rw; MemtoReg_in = m2r; RdAddr_in = rd;
        ALU_result_in = alu; MemData_in = mem; rf_ready = rdy;
    endtask

    initial begin
        int accepted;
        int cyc;

        tv[0]  = '{1'b1,1'b1,1'b0,5'd8, 32'h1234,32'h0,   1'b1, 5'd8,5'd0,  1'b1,1'b0,5'd0, 32'h0,   32'hDEAD,32'hBEEF};
        tv[1]  = '{1'b0,1'b0,1'b0,5'd0, 32'h0,   32'h0,   1'b1, 5'd8,5'd0,  1'b1,1'b1,5'd8, 32'h1234,32'h1234,32'hBEEF};
        tv[2]  = '{1'b1,1'b1,1'b1,5'd9, 32'hFFFF,32'hAAAA,1'b0, 5'd8,5'd0,  1'b1,1'b0,5'd0, 32'h0,   32'hDEAD,32'hBEEF};
        tv[3]  = '{1'b1,1'b1,1'b0,5'd10,32'h5555,32'h777, 1'b0, 5'd9,5'd10, 1'b1,1'b1,5'd9, 32'hAAAA,32'hAAAA,32'hBEEF};
        tv[4]  = '{1'b0,1'b0,1'b0,5'd0, 32'h0,   32'h0,   1'b0, 5'd9,5'd10, 1'b0,1'b1,5'd9, 32'hAAAA,32'hAAAA,32'h5555};
        tv[5]  = '{1'b1,1'b1,1'b0,5'd11,32'h6666,32'h0,   1'b1, 5'd9,5'd10, 1'b0,1'b1,5'd9, 32'hAAAA,32'hAAAA,32'h5555};
        tv[6]  = '{1'b0,1'b0,1'b0,5'd0, 32'h0,   32'h0,   1'b1, 5'd9,5'd10, 1'b1,1'b1,5'd10,32'h5555,32'hDEAD,32'h5555};
        tv[7]  = '{1'b1,1'b1,1'b0,5'd3, 32'h1,   32'h0,   1'b0, 5'd3,5'd0,  1'b1,1'b0,5'd0, 32'h0,   32'hDEAD,32'hBEEF};
        tv[8]  = '{1'b1,1'b1,1'b0,5'd3, 32'h2,   32'h0,   1'b0, 5'd3,5'd0,  1'b1,1'b1,5'd3, 32'h1,   32'h1,   32'hBEEF};
        tv[9]  = '{1'b0,1'b0,1'b0,5'd0, 32'h0,   32'h0,   1'b0, 5'd3,5'd0,  1'b0,1'b1,5'd3, 32'h1,   32'h2,   32'hBEEF};
        tv[10] = '{1'b0,1'b0,1'b0,5'd0, 32'h0,   32'h0,   1'b1, 5'd3,5'd0,  1'b0,1'b1,5'd3, 32'h1,   32'h2,   32'hBEEF};
        tv[11] = '{1'b0,1'b0,1'b0,5'd0, 32'h0,   32'h0,   1'b1, 5'd3,5'd0,  1'b1,1'b1,5'd3, 32'h2,   32'h2,   32'hBEEF};
        tv[12] = '{1'b1,1'b1,1'b0,5'd0, 32'h99,  32'h0,   1'b1, 5'd0,5'd0,  1'b1,1'b0,5'd0, 32'h0,   32'hDEAD,32'hBEEF};
        tv[13] = '{1'b1,1'b0,1'b0,5'd5, 32'h55,  32'h0,   1'b1, 5'd5,5'd0,  1'b1,1'b0,5'd0, 32'h0,   32'hDEAD,32'hBEEF};
        tv[14] = '{1'b0,1'b0,1'b0,5'd0, 32'h0,   32'h0,   1'b1, 5'd5,5'd0,  1'b1,1'b0,5'd0, 32'h0,   32'hDEAD,32'hBEEF};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        RsAddr = '0; RtAddr = '0; RsData_rf = 32'hDEAD; RtData_rf = 32'hBEEF;
        @(negedge clk);
        edge_step();
        edge_step();
        rst = 1'b0;
        #1;
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset.rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset.retire_cnt", retire_cnt, 32'd0);
        @(negedge clk);

        // Directed vectors with hand-derived expectations
        for (int i = 0; i < 15; i++) begin
            drive(tv[i].iv, tv[i].rw, tv[i].m2r, tv[i].rd, tv[i].alu, tv[i].mem, tv[i].rdy);
            RsAddr = tv[i].rs; RtAddr = tv[i].rt;
            #1;
            chk($sformatf("tv%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].e_rdy});
            chk($sformatf("tv%0d.rf_we", i),    {31'd0, rf_we},    {31'd0, tv[i].e_we});
            chk($sformatf("tv%0d.rf_waddr", i), {27'd0, rf_waddr}, {27'd0, tv[i].e_wa});
            chk($sformatf("tv%0d.rf_wdata", i), rf_wdata, tv[i].e_wd);
            chk($sformatf("tv%0d.rs_fwd", i),   RsData_fwd, tv[i].e_rs);
            chk($sformatf("tv%0d.rt_fwd", i),   RtData_fwd, tv[i].e_rt);
            edge_step();
        end
        #1;
        chk("tv.retire_cnt", retire_cnt, ret_exp(7));

        // Reset while the queue is full discards pending writes
        drive(1'b1, 1'b1, 1'b0, 5'd20, 32'h11, 32'h0, 1'b0);
        edge_step();
        drive(1'b1, 1'b1, 1'b0, 5'd21, 32'h22, 32'h0, 1'b0);
        edge_step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        RsAddr = 5'd20; RtAddr = 5'd21; RsData_rf = 32'hCAFE; RtData_rf = 32'hF00D;
        #1;
        check_model("full");
        chk("full.in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        #1;
        chk("rst2.rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst2.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst2.rs_fwd", RsData_fwd, 32'hCAFE);
        chk("rst2.rt_fwd", RtData_fwd, 32'hF00D);
        chk("rst2.retire_cnt", retire_cnt, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 32'h0, 1'b1);
        edge_step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        #1;
        chk("rst2.push7.we", {31'd0, rf_we}, 32'd1);
        chk("rst2.push7.waddr", {27'd0, rf_waddr}, 32'd7);
        chk("rst2.push7.wdata", rf_wdata, 32'h77);
        edge_step();

        // Randomized stream of 100 accepted instructions against the model
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        accepted = 0;
        model_writes = 0;
        dut_writes = 0;
        cyc = 0;
        while (accepted < 100 && cyc < 3000) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            RsAddr = AW'($urandom_range(0, 7)); RtAddr = AW'($urandom_range(0, 7));
            RsData_rf = $urandom; RtData_rf = $urandom;
            #1;
            check_model("rand");
            if (in_valid && mq_a.size() < D) accepted++;
            if (rf_we && rf_ready) dut_writes++;
            edge_step();
            cyc++;
        end
        chk("rand.accepted", accepted, 32'd100);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            #1;
            check_model("drain");
            if (rf_we && rf_ready) dut_writes++;
            edge_step();
        end
        #1;
        chk("drain.empty", {31'd0, rf_we}, 32'd0);
        chk("stream.write_count", dut_writes, model_writes);
        chk("stream.retire_cnt", retire_cnt, ret_exp(mret));
        chk("stream.retire_100", retire_cnt, ret_exp(100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
